// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Data-memory access sequencer for the MEM pipeline stage. A load or store
// request from the MEM stage is checked for alignment, latched, and presented
// on a handshaked RAM port. The pipeline is held with stall until the RAM
// acknowledges. Load data then comes back sign- or zero-extended to 32 bits.
// Misaligned or invalid-size requests and RAM timeouts are reported as
// one-cycle error pulses.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   mem_enable        MEM-stage access request (level, held while stalled)
//   mem_rw            1 = store, 0 = load
//   mem_size          00 byte, 01 halfword, 10 word, 11 invalid
//   mem_se            1 = sign-extend load data
//   addr, wdata       byte address and right-justified store data
//   stall             holds IF/ID/EX/MEM registers (combinational)
//   rdata             extended load data, valid with done on a load
//   done              one-cycle pulse: access completed
//   misalign_err      one-cycle pulse: misaligned or invalid-size request
//   timeout_err       one-cycle pulse: RAM did not answer within TIMEOUT cycles
//   ram_en .. ram_wdata  RAM request and latched request fields
//   ram_rdata, ram_ready RAM load data and one-cycle acknowledge
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_rw,
    input  logic [1:0]        mem_size,
    input  logic              mem_se,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last wait count before the access is declared timed out.
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    state_t              state_r;
    logic                rw_r;
    logic [1:0]          size_r;
    logic                se_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [3:0]          wait_cnt_r;
    logic                err_timeout_r;
    logic [31:0]         rdata_r;
    logic                unused_addr_bits_s;

    // Only the low ADDR_W address bits reach the RAM.
    assign unused_addr_bits_s = ^addr[31:ADDR_W];

    // Size 11 is never legal; halfword needs even, word needs 4-byte aligned.
    function automatic logic access_legal(input logic [1:0] size,
                                          input logic [1:0] low_addr);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (low_addr[0] == 1'b0);
            2'b10:   ok = (low_addr == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Extend the right-justified RAM field to 32 bits; word ignores se.
    function automatic logic [31:0] extend_load(input logic [31:0] d,
                                                input logic [1:0]  size,
                                                input logic        se);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{se & d[7]}}, d[7:0]};
            2'b01:   r = {{16{se & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Access sequencer: request latching, RAM wait counting, load capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rw_r          <= 1'b0;
            size_r        <= 2'b00;
            se_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= 32'd0;
            wait_cnt_r    <= 4'd0;
            err_timeout_r <= 1'b0;
            rdata_r       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_enable) begin
                        if (access_legal(mem_size, addr[1:0])) begin
                            rw_r       <= mem_rw;
                            size_r     <= mem_size;
                            se_r       <= mem_se;
                            addr_r     <= addr[ADDR_W-1:0];
                            wdata_r    <= wdata;
                            wait_cnt_r <= 4'd0;
                            state_r    <= ST_BUSY;
                        end else begin
                            err_timeout_r <= 1'b0;
                            state_r       <= ST_ERR;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // An acknowledge in the last allowed cycle still wins.
                    if (ram_ready) begin
                        if (!rw_r) begin
                            rdata_r <= extend_load(ram_rdata, size_r, se_r);
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r <= ST_DONE;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        err_timeout_r <= 1'b1;
                        state_r       <= ST_ERR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                // mem_enable seen in DONE still belongs to the finished access.
                ST_DONE: state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Stall is asserted in the request cycle itself, before any edge; reset
    // forces it low so an abandoned access releases the pipeline at once.
    assign stall = ~reset & (((state_r == ST_IDLE) & mem_enable) |
                             (state_r == ST_BUSY));

    assign done         = (state_r == ST_DONE);
    assign misalign_err = (state_r == ST_ERR) & ~err_timeout_r;
    assign timeout_err  = (state_r == ST_ERR) & err_timeout_r;
    assign rdata        = rdata_r;

    assign ram_en    = (state_r == ST_BUSY);
    assign ram_rw    = rw_r;
    assign ram_size  = size_r;
    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. Each access is described by its
// request fields, the number of RAM wait cycles and the RAM load data. A
// transaction-level reference computes legality, the expected busy length,
// the outcome pulse and the extended load value arithmetically.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              reset;
    logic              mem_enable;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic              mem_se;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              done;
    logic              misalign_err;
    logic              timeout_err;
    logic              ram_en;
    logic              ram_rw;
    logic [1:0]        ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_rdata = 32'd0;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_size     (mem_size),
        .mem_se       (mem_se),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .done         (done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .ram_en       (ram_en),
        .ram_rw       (ram_rw),
        .ram_size     (ram_size),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_ready    (ram_ready)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input int size, input longint a);
        if (size == 3) return 1'b0;
        if (size == 1) return (a % 2) == 0;
        if (size == 2) return (a % 4) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_extend(input int size, input bit se,
                                               input longint d);
        longint v;
        if (size == 0) begin
            v = d % 256;
            if (se && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = d % 65536;
            if (se && v >= 32768) v = v - 65536;
        end else begin
            v = d;
        end
        if (v < 0) v = v + 64'h1_0000_0000;
        return 32'(v);
    endfunction

    // One access. lat = RAM wait cycles before ready; lat >= TIMEOUT means
    // the RAM never answers.
    task automatic do_txn(input int size, input bit se, input bit rw,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input logic [31:0] rd);
        bit legal;
        int nbusy;
        bit ok_done;
        legal   = ref_legal(size, longint'(a));
        ok_done = legal && (lat < TIMEOUT);
        nbusy   = !legal ? 0 : ((lat < TIMEOUT) ? lat + 1 : TIMEOUT);

        @(negedge clk);
        mem_enable = 1'b1;
        mem_size   = 2'(size);
        mem_se     = se;
        mem_rw     = rw;
        addr       = a;
        wdata      = wd;
        ram_ready  = 1'b0;
        #1;
        check("req_stall", 32'(stall), 32'd1);
        check("req_ram_en", 32'(ram_en), 32'd0);

        for (int k = 0; k < nbusy; k++) begin
            @(negedge clk);
            check("busy_ram_en", 32'(ram_en), 32'd1);
            check("busy_stall", 32'(stall), 32'd1);
            if (k == 0 || k == nbusy - 1) begin
                check("ram_addr", 32'(ram_addr), a % (32'd1 << ADDR_W));
                check("ram_rw", 32'(ram_rw), 32'(rw));
                check("ram_size", 32'(ram_size), 32'(size));
                check("ram_wdata", ram_wdata, wd);
            end
            // The pipeline holds its request, but the fields must be latched.
            addr  = $urandom;
            wdata = $urandom;
            if (k == lat) begin
                ram_ready = 1'b1;
                ram_rdata = rd;
            end else begin
                ram_ready = 1'b0;
                ram_rdata = $urandom;
            end
        end

        @(negedge clk);
        ram_ready = 1'b0;
        if (ok_done && !rw) model_rdata = ref_extend(size, se, longint'(rd));
        check("end_done", 32'(done), 32'(ok_done));
        check("end_misalign", 32'(misalign_err), 32'(!legal));
        check("end_timeout", 32'(timeout_err), 32'(legal && lat >= TIMEOUT));
        check("end_stall", 32'(stall), 32'd0);
        check("end_ram_en", 32'(ram_en), 32'd0);
        check("end_rdata", rdata, model_rdata);

        // mem_enable is still high in DONE/ERR; it must not start a new access.
        @(negedge clk);
        mem_enable = 1'b0;
        ram_ready  = $urandom_range(0, 1) == 1;
        #1;
        check("idle_ram_en", 32'(ram_en), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_rdata", rdata, model_rdata);
        ram_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_size   = 2'b00;
        mem_se     = 1'b0;
        addr       = 32'd0;
        wdata      = 32'd0;
        ram_rdata  = 32'd0;
        ram_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_errs", 32'({misalign_err, timeout_err}), 32'd0);
        reset = 1'b0;

        // Directed accesses.
        do_txn(2, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 0, 32'h89AB_CDEF);
        do_txn(0, 1'b1, 1'b0, 32'h0000_0003, 32'd0, 3, 32'h0000_0080);
        do_txn(0, 1'b0, 1'b0, 32'h0000_0003, 32'd0, 3, 32'h0000_0080);
        do_txn(1, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_1234, 2, 32'hDEAD_BEEF);
        do_txn(1, 1'b1, 1'b0, 32'h0000_0202, 32'd0, 1, 32'h1234_8001);
        do_txn(2, 1'b0, 1'b0, 32'h0000_0006, 32'd0, 0, 32'd0);
        do_txn(3, 1'b0, 1'b0, 32'h0000_0000, 32'd0, 0, 32'd0);
        do_txn(2, 1'b0, 1'b0, 32'h0000_0040, 32'd0, TIMEOUT, 32'd0);
        do_txn(2, 1'b0, 1'b0, 32'h0000_0044, 32'd0, TIMEOUT - 1, 32'h0BAD_F00D);

        // Randomized accesses.
        for (int t = 0; t < 60; t++) begin
            do_txn(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, TIMEOUT + 2)), $urandom);
        end

        // Reset in the middle of a BUSY access.
        @(negedge clk);
        mem_enable = 1'b1;
        mem_rw     = 1'b0;
        mem_size   = 2'b10;
        addr       = 32'h0000_0100;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_ram_en", 32'(ram_en), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ram_en", 32'(ram_en), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        mem_enable  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_txn(0, 1'b1, 1'b0, 32'h0000_0101, 32'd0, 1, 32'h0000_00F0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM pipeline stage. Takes the MEM-stage memory control bits (enable, read/write, size, sign-extend) plus address and store data, and drives a handshaked RAM port. Holds the pipeline with a stall signal until the RAM acknowledges, then returns load data extended to 32 bits. Flags misaligned accesses and RAM timeouts.

Parameters:
ADDR_W, 9, width of RAM byte address driven on ram_addr (low ADDR_W bits of addr).
TIMEOUT, 15, max BUSY cycles without ram_ready before timeout error (1..15).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mem_enable  in  1  MEM-stage memory access request (level, held while stalled).
mem_rw  in  1  1 = store, 0 = load.
mem_size  in  2  00 byte, 01 halfword, 10 word, 11 invalid.
mem_se  in  1  1 = sign-extend load data, 0 = zero-extend.
addr  in  32  byte address from ALU result.
wdata  in  32  store data, right-justified.
stall  out  1  hold IF/ID/EX/MEM pipeline registers.
rdata  out  32  extended load data, valid when done=1 and load.
done  out  1  one-cycle pulse: access completed.
misalign_err  out  1  one-cycle pulse: misaligned or invalid-size request.
timeout_err  out  1  one-cycle pulse: RAM did not respond in time.
ram_en  out  1  RAM request, held until ram_ready.
ram_rw  out  1  latched mem_rw.
ram_size  out  2  latched mem_size.
ram_addr  out  ADDR_W  latched addr[ADDR_W-1:0].
ram_wdata  out  32  latched wdata.
ram_rdata  in  32  RAM load data, right-justified, valid with ram_ready.
ram_ready  in  1  RAM acknowledge, one cycle.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs and latches 0; wait_cnt 0. Reset during BUSY drops ram_en same instant; access is abandoned.
- States: IDLE, BUSY, DONE, ERR.
- IDLE: if mem_enable=0 stay, stall=0. If mem_enable=1: stall=1 combinationally this cycle. Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal. Illegal -> ERR, no RAM access, set err_kind=misalign. Legal -> latch rw/size/se/addr/wdata, wait_cnt=0, -> BUSY.
- BUSY: ram_en=1, stall=1, ram_* from latches (stable whole state). If ram_ready=1: for load capture extended ram_rdata into rdata; for store rdata unchanged; -> DONE. Else if wait_cnt==TIMEOUT-1: -> ERR, err_kind=timeout. Else wait_cnt+1. ram_ready wins over timeout in the same cycle.
- DONE: done=1, stall=0 (pipeline advances on this edge), ram_en=0; -> IDLE unconditionally. mem_enable seen in DONE is the old instruction and is ignored.
- ERR: stall=0, misalign_err or timeout_err =1 per err_kind, done=0, rdata unchanged; -> IDLE.
- Extension: byte uses ram_rdata[7:0], halfword [15:0], word [31:0]; upper bits = se ? MSB of field : 0. Word ignores se.
- Minimum latency: request cycle N (IDLE), ram_en cycle N+1, ready in N+1 -> done at N+2. Each extra RAM wait cycle adds one.
- ram_rdata ignored outside BUSY; ram_ready outside BUSY ignored.
- All outputs except stall are registered or decoded from state only; stall combinational from state and mem_enable.

Test Plan:
- Word load addr=0x10, ram_ready in first BUSY cycle, ram_rdata=0x89ABCDEF -> stall=1 two cycles, done pulse cycle N+2, rdata=0x89ABCDEF, ram_addr=0x010.
- Byte load se=1 addr=0x03, ram_rdata=0x00000080, ready after 3 wait cycles -> rdata=0xFFFFFF80, stall high 5 cycles; same with se=0 -> rdata=0x00000080.
- Halfword store addr=0x22 wdata=0x1234 -> ram_rw=1, ram_size=01, ram_wdata=0x00001234 stable until ready, done pulse, rdata unchanged.
- Misaligned word addr=0x06 and size=11 -> no ram_en ever, misalign_err pulse at N+1, stall only in cycle N.
- ram_ready never asserted, TIMEOUT=15 -> ram_en high exactly 15 cycles, timeout_err pulse, stall released; ready on the 15th cycle instead -> done, no error.
- Assert reset during BUSY -> ram_en, stall, done fall without a clock edge; next request after reset completes normally.
